// File: rtl/ysyx_22050612_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_mdu_pkg
// Description : Shared op codes, FSM state type and helpers for the EXU
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050612_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Division/remainder ops occupy the upper half of the op space.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050612_mdu_divstep.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_mdu_divstep
// Description : One restoring-division step: shift the next dividend bit into
//               the partial remainder and subtract the divisor if it fits.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050612_mdu_divstep #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    // The partial remainder is always below the divisor, so the shifted value
    // fits in W+1 bits and the difference (when taken) fits in W bits.
    assign w_shift = {rem_i, bit_i};
    assign q_o     = (w_shift >= {1'b0, divisor_i});
    assign w_diff  = w_shift[W-1:0] - divisor_i;
    assign rem_o   = q_o ? w_diff : w_shift[W-1:0];

endmodule
`default_nettype wire

// File: rtl/ysyx_22050612_exu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050612_exu_mdu
// Description : Iterative RV64M multiply/divide unit (one bit per cycle) with
//               valid/ready handshakes on request and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050612_exu_mdu
    import ysyx_22050612_mdu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter bit WORD_EN = 1'b1,
    parameter int RW      = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [RW-1:0]   rd_in_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [RW-1:0]   rd_out_o,
    output logic            busy_o
);

    localparam int              CW     = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] C_XMIN = {1'b1, {(XLEN-1){1'b0}}};

    // Replace bits above 31 with the sign (or zero) of bit 31 in word mode.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v,
                                              input logic word, input logic sgn);
        logic [XLEN-1:0] r;
        r = v;
        if (word) begin
            for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        end
        return r;
    endfunction

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;
    logic [XLEN-1:0]   a_q;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] p_q;       // product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]   result_q;
    logic [RW-1:0]     rd_out_q;
    logic              out_valid_q;

    // ---------------- request decode ----------------
    logic            w_word, w_s1_signed, w_s2_signed, w_is_div;
    logic            w_neg1, w_neg2, w_neg_res, w_div0, w_ovf, w_accept;
    logic [XLEN-1:0] w_x1, w_x2, w_mag1, w_mag2, w_lo_init, w_special_raw;

    assign w_word      = WORD_EN && word_i;
    assign w_s1_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    assign w_s2_signed = w_s1_signed && (op_i != OP_MULHSU);
    assign w_is_div    = is_div(op_i);
    assign w_x1        = ext32(src1_i, w_word, w_s1_signed);
    assign w_x2        = ext32(src2_i, w_word, w_s2_signed);
    assign w_neg1      = w_s1_signed & w_x1[XLEN-1];
    assign w_neg2      = w_s2_signed & w_x2[XLEN-1];
    assign w_mag1      = w_neg1 ? -w_x1 : w_x1;
    assign w_mag2      = w_neg2 ? -w_x2 : w_x2;
    // Remainder follows the dividend; product and quotient follow sign XOR.
    assign w_neg_res   = (w_is_div && op_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    assign w_div0      = w_is_div && (w_x2 == '0);
    assign w_ovf       = w_is_div && !op_i[0] &&
                         (w_word ? ((w_x1[31:0] == 32'h8000_0000) && (w_x2[31:0] == 32'hFFFF_FFFF))
                                 : ((w_x1 == C_XMIN) && (w_x2 == '1)));
    // On overflow the dividend already equals MIN at the active width.
    assign w_special_raw = w_div0 ? (op_i[1] ? w_x1 : '1) : (op_i[1] ? '0 : w_x1);
    // Word-mode division starts with the 32-bit dividend at the top of the
    // shift register so its MSB is the first bit consumed.
    assign w_lo_init   = w_is_div ? (w_word ? (w_mag1 << (XLEN - 32)) : w_mag1) : w_mag2;
    assign in_ready_o  = (state_q == S_IDLE) && !rst;
    assign w_accept    = in_valid_i && in_ready_o && !flush_i;

    // ---------------- iteration step ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN-1:0]   w_rem_d;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_p_d;

    assign w_mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);

    ysyx_22050612_mdu_divstep #(.W(XLEN)) u_divstep (
        .rem_i     (p_q[2*XLEN-1:XLEN]),
        .bit_i     (p_q[XLEN-1]),
        .divisor_i (a_q),
        .rem_o     (w_rem_d),
        .q_o       (w_qbit)
    );

    assign w_p_d = is_div(op_q) ? {w_rem_d, p_q[XLEN-2:0], w_qbit}
                                : {w_mul_sum, p_q[XLEN-1:1]};

    // ---------------- sign fixup and select ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_calc_raw;

    assign w_prod = neg_q ? -p_q : p_q;
    assign w_quo  = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    assign w_rem  = neg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];

    // Pick the architectural result; word MUL low bits sit 32 below XLEN.
    always_comb begin
        w_calc_raw = w_prod[2*XLEN-1:XLEN];
        if (is_div(op_q)) begin
            w_calc_raw = op_q[1] ? w_rem : w_quo;
        end else if (op_q == OP_MUL) begin
            w_calc_raw = word_q ? XLEN'(w_prod[XLEN-32 +: 32]) : w_prod[XLEN-1:0];
        end
    end

    // Control FSM plus datapath registers; flush aborts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            word_q      <= 1'b0;
            neg_q       <= 1'b0;
            a_q         <= '0;
            p_q         <= '0;
            result_q    <= '0;
            rd_out_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        op_q     <= op_i;
                        word_q   <= w_word;
                        neg_q    <= w_neg_res;
                        rd_out_q <= rd_in_i;
                        if (w_div0 || w_ovf) begin
                            result_q <= ext32(w_special_raw, w_word, 1'b1);
                            state_q  <= S_DONE;
                        end else begin
                            a_q     <= w_is_div ? w_mag2 : w_mag1;
                            p_q     <= {{XLEN{1'b0}}, w_lo_init};
                            cnt_q   <= w_word ? CW'(32) : CW'(XLEN);
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (cnt_q != '0) begin
                        p_q   <= w_p_d;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q    <= ext32(w_calc_raw, word_q, 1'b1);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Special-case results enter DONE silently and raise
                    // out_valid one cycle after accept.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign rd_out_o    = rd_out_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050612_exu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050612_exu_mdu
// Description : Directed self-checking bench for the iterative MDU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050612_exu_mdu;

    localparam logic [2:0] C_MUL = 3'd0, C_MULHU = 3'd3, C_DIV = 3'd4,
                           C_DIVU = 3'd5, C_REM = 3'd6, C_REMU = 3'd7;

    logic        clk, rst, in_valid, in_ready, word, flush;
    logic        out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [63:0] src1, src2, result;
    logic [4:0]  rd_in, rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22050612_exu_mdu #(.XLEN(64), .WORD_EN(1'b1), .RW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .word_i      (word),
        .src1_i      (src1),
        .src2_i      (src2),
        .rd_in_i     (rd_in),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .rd_out_o    (rd_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure cycles from accept edge to out_valid
    // (200 means it never came), optionally consume the result.
    task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit consume,
                         output int lat, output logic [63:0] res, output logic [4:0] rdo);
        op = o; word = w; src1 = a; src2 = b; rd_in = rd; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        res = result;
        rdo = rd_out;
        if (consume && out_valid) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
        n_checks++;
        if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d want 0", rd_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_mul();
        int lat; logic [63:0] r; logic [4:0] t;
        do_op(C_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 1'b1, lat, r, t);
        n_checks++;
        if (lat != 65) begin n_fail++; $display("FAIL mul_latency: got %0d want 65", lat); end
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffffffffffeb", r); end
        n_checks++;
        if (t !== 5'd3) begin n_fail++; $display("FAIL mul_rd: got %0d want 3", t); end
        do_op(C_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 1'b1, lat, r, t);
        n_checks++;
        if (r !== 64'd1) begin n_fail++; $display("FAIL mulhu_result: got %h want 1", r); end
    endtask

    task automatic test_div_special();
        int lat; logic [63:0] r; logic [4:0] t;
        do_op(C_DIVU, 1'b0, 64'd100, 64'd0, 5'd5, 1'b1, lat, r, t);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL divu0_latency: got %0d want 1", lat); end
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL divu0_result: got %h want all ones", r); end
        do_op(C_REMU, 1'b0, 64'd100, 64'd0, 5'd6, 1'b1, lat, r, t);
        n_checks++;
        if (r !== 64'd100) begin n_fail++; $display("FAIL remu0_result: got %h want 64", r); end
        do_op(C_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b1, lat, r, t);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL divovf_latency: got %0d want 1", lat); end
        n_checks++;
        if (r !== 64'h8000_0000_0000_0000) begin n_fail++; $display("FAIL divovf_result: got %h want 8000000000000000", r); end
        do_op(C_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, lat, r, t);
        n_checks++;
        if (r !== 64'd0) begin n_fail++; $display("FAIL removf_result: got %h want 0", r); end
    endtask

    task automatic test_word();
        int lat; logic [63:0] r; logic [4:0] t;
        do_op(C_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd10, 1'b1, lat, r, t);
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL divw_latency: got %0d want 33", lat); end
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL divw_result: got %h want fffffffffffffffd", r); end
        do_op(C_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd11, 1'b1, lat, r, t);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL remw_result: got %h want ffffffffffffffff", r); end
        do_op(C_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd12, 1'b1, lat, r, t);
        n_checks++;
        if (lat != 33) begin n_fail++; $display("FAIL mulw_latency: got %0d want 33", lat); end
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mulw_result: got %h want fffffffffffffffe", r); end
    endtask

    task automatic test_backpressure();
        int lat; logic [63:0] r; logic [4:0] t;
        do_op(C_DIV, 1'b0, 64'd100, 64'd7, 5'd13, 1'b0, lat, r, t);
        n_checks++;
        if (lat != 65) begin n_fail++; $display("FAIL bp_latency: got %0d want 65", lat); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++;
            if (result !== 64'd14) begin n_fail++; $display("FAIL bp_result[%0d]: got %h want e", i, result); end
            n_checks++;
            if (rd_out !== 5'd13) begin n_fail++; $display("FAIL bp_rd[%0d]: got %0d want 13", i, rd_out); end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        int lat; logic [63:0] r; logic [4:0] t; bit seen;
        op = C_MUL; word = 1'b0; src1 = 64'd11; src2 = 64'd13; rd_in = 5'd20; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1; in_valid = 1'b1; src1 = 64'd2; src2 = 64'd2; rd_in = 5'd21;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL flush_no_valid: got out_valid seen want never"); end
        do_op(C_MUL, 1'b0, 64'd3, 64'd5, 5'd9, 1'b1, lat, r, t);
        n_checks++;
        if (r !== 64'd15) begin n_fail++; $display("FAIL post_flush_result: got %h want f", r); end
        n_checks++;
        if (t !== 5'd9) begin n_fail++; $display("FAIL post_flush_rd: got %0d want 9", t); end
    endtask

    task automatic test_rst_mid();
        int lat; logic [63:0] r; logic [4:0] t;
        op = C_MUL; word = 1'b0; src1 = 64'd6; src2 = 64'd7; rd_in = 5'd17; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstcalc_valid: got %b want 0", out_valid); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL rstcalc_result: got %h want 0", result); end
        n_checks++;
        if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rstcalc_rd: got %0d want 0", rd_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstcalc_busy: got %b want 0", busy); end
        do_op(C_DIVU, 1'b0, 64'd55, 64'd0, 5'd18, 1'b0, lat, r, t);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL rstdone_pre_result: got %h want all ones", r); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstdone_valid: got %b want 0", out_valid); end
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL rstdone_result: got %h want 0", result); end
        n_checks++;
        if (rd_out !== 5'd0) begin n_fail++; $display("FAIL rstdone_rd: got %0d want 0", rd_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstdone_busy: got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; word = 1'b0; src1 = '0; src2 = '0;
        rd_in = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div_special();
        test_word();
        test_backpressure();
        test_flush();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22050612_exu_mdu.md
Name: ysyx_22050612_exu_mdu

Overview:
Iterative multiply/divide unit for the EXU; it executes the RV64M group (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus the W forms).
- Parametrised in datapath width.
- Uses valid/ready handshakes on both sides, so the EXU can stall on multi-cycle ops while single-cycle ALU ops keep using the existing adder path.
- Result and rd tag go to the GPR write-back mux.

Parameters:
XLEN, 64, datapath width (32 or 64)
WORD_EN, 1, enables W-form ops (legal only when XLEN==64; tie `word` low otherwise)
RW, 5, register-index width for the rd tag

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
in_valid  in  1  request present
in_ready  out  1  unit can accept (high only in IDLE)
op  in  3  operation code (package constants)
word  in  1  W-form: use low 32 bits, sign-extend the 32-bit result
src1  in  XLEN  rs1 value
src2  in  XLEN  rs2 value
rd_in  in  RW  destination tag
flush  in  1  abort current op (sync, highest priority after rst)
out_valid  out  1  result present
out_ready  in  1  consumer takes result
result  out  XLEN  final value
rd_out  out  RW  tag captured at accept
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CALC, DONE.
- Reset: state=IDLE, out_valid=0, result=0, rd_out=0, busy=0, in_ready=1 after the reset cycle. In_ready is 0 during reset.
- Accept: on the edge where in_valid&&in_ready&&!flush, latch op/word/rd_in and operands.
  - Word mode: operands are src[31:0], sign- or zero-extended per op signedness.
  - Magnitudes are taken for signed ops; result sign flags are stored.
- Iteration count N = 32 if word else XLEN.
- CALC runs N cycles, one bit per cycle:
  - MUL*: radix-2 shift-add on a 2N-bit product register.
  - DIV*/REM*: restoring divider with an N-bit remainder and quotient.
  - The counter decrements each cycle; on 0, sign fixup and select happen and the state moves to DONE.
  - out_valid rises exactly N+1 cycles after the accept edge.
- Special cases skip CALC (accept -> DONE, out_valid on the next cycle):
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - Both are computed at N width and then extended.
- Result select: MUL takes the low N product bits. MULH/MULHSU/MULHU take the high N bits (illegal when word=1; output is don't-care). Quotient for DIV*, remainder for REM*.
- Word results: sign-extend bit 31 to XLEN, for all W ops including DIVUW/REMUW.
- DONE: result and rd_out are held stable while out_valid=1 && out_ready=0. The handshake edge leads to IDLE with out_valid=0.
  - No accept in the same cycle as out handshake; in_ready is 0 in DONE.
- Flush: in any state, the next state is IDLE and out_valid=0 on the next cycle. Flush has priority over in_valid and out_ready.
  - A flushed result is never presented.
  - Flush in IDLE is a no-op.
- rst mid-operation: identical to flush, plus result/rd_out are cleared.
- Sign fixup:
  - Product is negated if the operand signs differ (MULHSU: src1 sign only).
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Widths: internal product register 2*XLEN; all other arithmetic is modulo 2^XLEN.

Decomposition:
- Package ysyx_22050612_mdu_pkg:
  - Op constants: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - State encoding: IDLE=0, CALC=1, DONE=2.
  - Helper `is_div = op[2]`.
- One sub-module is natural: ysyx_22050612_mdu_divstep, a combinational restoring-division single step (remainder, divisor -> new remainder, quotient bit), reused for both word and full widths.
- The multiplier step stays inline in the top module.

Test Plan:
- Reset, then MUL src1=7, src2=0xFFFFFFFFFFFFFFFD -> out_valid at accept+65 cycles, result=0xFFFFFFFFFFFFFFEB; MULHU src1=0xFFFFFFFFFFFFFFFF, src2=2 -> result=1.
- DIVU 100/0 -> out_valid at accept+1, result=0xFFFFFFFFFFFFFFFF; REMU 100/0 -> result=100; DIV 0x8000000000000000/0xFFFFFFFFFFFFFFFF -> 0x8000000000000000, REM of the same operands -> 0.
- DIVW src1=0x12345678FFFFFFF9, src2=2 -> out_valid at accept+33, result=0xFFFFFFFFFFFFFFFD; REMW of the same operands -> 0xFFFFFFFFFFFFFFFF; MULW 0x7FFFFFFF*2 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure: DIV 100/7 with out_ready=0 for 5 cycles after out_valid -> result=14 and rd_out held stable, in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Flush at CALC cycle 10 of MUL with in_valid also high -> no accept that cycle, IDLE next cycle, out_valid never rises; a following MUL 3*5 returns 15 with the new rd tag.
- rst asserted mid-CALC and in DONE -> next cycle out_valid=0, result=0, rd_out=0, busy=0.
